// File: rtl/uart_byte_port.sv
// uart_byte_port: byte-wide request/ack port in front of an 8N1 UART.
// TX bytes are buffered in a FIFO and serialised on Tx; bytes deserialised
// from Rx are buffered in a second FIFO that the controller drains.
module uart_byte_port #(
   parameter int CLK_DIV     = 868,
   parameter int FIFO_ADDR_L = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] u_din,
   input  logic       u_we,
   output logic       u_wack,
   output logic       u_wa,
   output logic [7:0] u_dout,
   input  logic       u_re,
   output logic       u_rack,
   output logic       u_ra,
   output logic       Tx,
   input  logic       Rx,
   output logic       frame_err,
   output logic       rx_ovf
);

   localparam int DEPTH = 1 << FIFO_ADDR_L;
   localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]          BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]          HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0]          CNT_STEP  = CW'(1);
   localparam logic [FIFO_ADDR_L:0]   CNT_FULL  = (FIFO_ADDR_L + 1)'(DEPTH);
   localparam logic [FIFO_ADDR_L:0]   CNT_ONE   = (FIFO_ADDR_L + 1)'(1);
   localparam logic [FIFO_ADDR_L-1:0] PTR_ONE   = FIFO_ADDR_L'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // ---------------- TX FIFO ----------------
   logic [7:0]             tx_mem [DEPTH];
   logic [FIFO_ADDR_L-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [FIFO_ADDR_L:0]   tx_count, tx_count_next;
   logic                   tx_push, tx_pop;

   // The ~u_wack term stops a still-held u_we from pushing twice.
   assign tx_push = u_we & ~u_wack & u_wa;

   // TX occupancy after this cycle's push/pop.
   always_comb begin
      tx_count_next = tx_count;
      if (tx_push) tx_count_next = tx_count_next + CNT_ONE;
      if (tx_pop)  tx_count_next = tx_count_next - CNT_ONE;
   end

   // TX FIFO storage write port.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= u_din;
   end

   // TX FIFO pointers, count, space flag and write ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         u_wa      <= 1'b1;
         u_wack    <= 1'b0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         tx_count <= tx_count_next;
         u_wa     <= (tx_count_next != CNT_FULL);
         u_wack   <= tx_push;
      end
   end

   // ---------------- TX serialiser ----------------
   state_t        tx_state, tx_state_next;
   logic [CW-1:0] tx_bit_cnt, tx_bit_cnt_next;
   logic [2:0]    tx_bit_idx, tx_bit_idx_next;
   logic [7:0]    tx_shift;
   logic          tx_shift_en;

   // TX FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= IDLE;
         tx_bit_cnt <= '0;
         tx_bit_idx <= '0;
      end else begin
         tx_state   <= tx_state_next;
         tx_bit_cnt <= tx_bit_cnt_next;
         tx_bit_idx <= tx_bit_idx_next;
      end
   end

   // TX FSM next state: each state lasts CLK_DIV cycles; IDLE pops the FIFO.
   always_comb begin
      tx_state_next   = tx_state;
      tx_bit_cnt_next = tx_bit_cnt + CNT_STEP;
      tx_bit_idx_next = tx_bit_idx;
      tx_pop          = 1'b0;
      tx_shift_en     = 1'b0;
      unique case (tx_state)
         IDLE: begin
            tx_bit_cnt_next = '0;
            if (tx_count != '0) begin
               tx_pop        = 1'b1;
               tx_state_next = START;
            end
         end
         START: begin
            if (tx_bit_cnt == BIT_LAST) begin
               tx_bit_cnt_next = '0;
               tx_bit_idx_next = '0;
               tx_state_next   = DATA;
            end
         end
         DATA: begin
            if (tx_bit_cnt == BIT_LAST) begin
               tx_bit_cnt_next = '0;
               tx_shift_en     = 1'b1;
               tx_bit_idx_next = tx_bit_idx + 3'd1;
               if (tx_bit_idx == 3'd7) tx_state_next = STOP;
            end
         end
         STOP: begin
            if (tx_bit_cnt == BIT_LAST) begin
               tx_bit_cnt_next = '0;
               tx_state_next   = IDLE;
            end
         end
         default: tx_state_next = IDLE;
      endcase
   end

   // Shift register loads straight from the FIFO array (registered read).
   always_ff @(posedge clk) begin
      if (tx_pop)           tx_shift <= tx_mem[tx_rd_ptr];
      else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
   end

   // Registered line driver, one cycle behind the FSM state.
   always_ff @(posedge clk) begin
      if (rst) Tx <= 1'b1;
      else begin
         unique case (tx_state)
            START:   Tx <= 1'b0;
            DATA:    Tx <= tx_shift[0];
            default: Tx <= 1'b1;
         endcase
      end
   end

   // ---------------- RX deserialiser ----------------
   logic          rx_meta, rx_sync, rx_prev;
   state_t        rx_state, rx_state_next;
   logic [CW-1:0] rx_bit_cnt, rx_bit_cnt_next;
   logic [2:0]    rx_bit_idx, rx_bit_idx_next;
   logic [7:0]    rx_shift;
   logic          rx_shift_en, rx_done;

   // Two-flop synchroniser plus a delayed copy for start-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // RX FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state   <= IDLE;
         rx_bit_cnt <= '0;
         rx_bit_idx <= '0;
      end else begin
         rx_state   <= rx_state_next;
         rx_bit_cnt <= rx_bit_cnt_next;
         rx_bit_idx <= rx_bit_idx_next;
      end
   end

   // RX FSM: mid-bit sampling; STOP returns to IDLE right after its sample.
   always_comb begin
      rx_state_next   = rx_state;
      rx_bit_cnt_next = rx_bit_cnt + CNT_STEP;
      rx_bit_idx_next = rx_bit_idx;
      rx_shift_en     = 1'b0;
      rx_done         = 1'b0;
      unique case (rx_state)
         IDLE: begin
            rx_bit_cnt_next = '0;
            if (rx_prev && !rx_sync) rx_state_next = START;
         end
         START: begin
            if (rx_bit_cnt == HALF_LAST) begin
               rx_bit_cnt_next = '0;
               rx_bit_idx_next = '0;
               rx_state_next   = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (rx_bit_cnt == BIT_LAST) begin
               rx_bit_cnt_next = '0;
               rx_shift_en     = 1'b1;
               rx_bit_idx_next = rx_bit_idx + 3'd1;
               if (rx_bit_idx == 3'd7) rx_state_next = STOP;
            end
         end
         STOP: begin
            if (rx_bit_cnt == BIT_LAST) begin
               rx_bit_cnt_next = '0;
               rx_done         = 1'b1;
               rx_state_next   = IDLE;
            end
         end
         default: rx_state_next = IDLE;
      endcase
   end

   // Data bits arrive LSB first, so shift in from the top.
   always_ff @(posedge clk) begin
      if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]             rx_mem [DEPTH];
   logic [FIFO_ADDR_L-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [FIFO_ADDR_L:0]   rx_count, rx_count_next;
   logic                   rx_push, rx_pop;

   // Full test uses the pre-pop count: a same-cycle read does not save the byte.
   assign rx_push = rx_done & rx_sync & (rx_count != CNT_FULL);
   assign rx_pop  = u_re & ~u_rack & u_ra;

   // RX occupancy after this cycle's push/pop.
   always_comb begin
      rx_count_next = rx_count;
      if (rx_push) rx_count_next = rx_count_next + CNT_ONE;
      if (rx_pop)  rx_count_next = rx_count_next - CNT_ONE;
   end

   // RX FIFO storage write port.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
   end

   // RX FIFO pointers, count, read data/ack and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         u_ra      <= 1'b0;
         u_rack    <= 1'b0;
         u_dout    <= '0;
         frame_err <= 1'b0;
         rx_ovf    <= 1'b0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            u_dout    <= rx_mem[rx_rd_ptr];
         end
         rx_count  <= rx_count_next;
         u_ra      <= (rx_count_next != '0);
         u_rack    <= rx_pop;
         frame_err <= rx_done & ~rx_sync;
         rx_ovf    <= rx_done & rx_sync & (rx_count == CNT_FULL);
      end
   end

endmodule

// File: tb/tb_uart_byte_port.sv
// Testbench for uart_byte_port with CLK_DIV=8 and 4-entry FIFOs.
// Expected read bytes go through a queue scoreboard; each scenario task
// drives its stimulus and checks its own results.
module tb_uart_byte_port;

   localparam int CLK_DIV     = 8;
   localparam int FIFO_ADDR_L = 2;

   logic       clk = 1'b0;
   logic       rst, u_we, u_re, rx_drive, loopback;
   logic [7:0] u_din;
   logic       u_wack, u_wa, u_rack, u_ra, tx_line, rx_line, frame_err, rx_ovf;
   logic [7:0] u_dout;

   int vectors     = 0;
   int miscompares = 0;
   int ferr_cnt    = 0;
   int ovf_cnt     = 0;
   int cyc         = 0;
   logic [7:0] exp_q [$];

   assign rx_line = loopback ? tx_line : rx_drive;

   uart_byte_port #(.CLK_DIV(CLK_DIV), .FIFO_ADDR_L(FIFO_ADDR_L)) dut (
      .clk(clk), .rst(rst),
      .u_din(u_din), .u_we(u_we), .u_wack(u_wack), .u_wa(u_wa),
      .u_dout(u_dout), .u_re(u_re), .u_rack(u_rack), .u_ra(u_ra),
      .Tx(tx_line), .Rx(rx_line), .frame_err(frame_err), .rx_ovf(rx_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (rx_ovf === 1'b1)    ovf_cnt  <= ovf_cnt + 1;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, want finish within 1ms");
      $fatal(1, "watchdog");
   end

   // 8N1 frame as seen on the line: index 0 = start bit, 9 = stop bit.
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   task automatic write_byte(input logic [7:0] b, output bit ok);
      u_din = b;
      u_we  = 1'b1;
      ok    = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (u_wack === 1'b1) ok = 1'b1;
      end
      u_we = 1'b0;
      $display("write 0x%02h ack=%0b", b, ok);
   endtask

   task automatic read_byte(output logic [7:0] d, output bit ok);
      u_re = 1'b1;
      ok   = 1'b0;
      d    = 8'h00;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (u_rack === 1'b1) begin
            ok = 1'b1;
            d  = u_dout;
         end
      end
      u_re = 1'b0;
      $display("read 0x%02h ack=%0b", d, ok);
   endtask

   // Called at the first negedge showing the start bit; samples mid-bit.
   task automatic sample_frame(output logic [9:0] f);
      repeat (3) @(negedge clk);
      f[0] = tx_line;
      for (int k = 1; k < 10; k++) begin
         repeat (8) @(negedge clk);
         f[k] = tx_line;
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rx_drive = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drive = b[i];
         repeat (8) @(negedge clk);
      end
      rx_drive = stop_bit;
      repeat (8) @(negedge clk);
      rx_drive = 1'b1;
      repeat (4) @(negedge clk);
      $display("rx frame 0x%02h stop=%0b", b, stop_bit);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (u_wack !== 1'b0)    begin miscompares++; $display("FAIL rst_u_wack: got %b want 0", u_wack); end
      vectors++; if (u_rack !== 1'b0)    begin miscompares++; $display("FAIL rst_u_rack: got %b want 0", u_rack); end
      vectors++; if (u_dout !== 8'h00)   begin miscompares++; $display("FAIL rst_u_dout: got %h want 00", u_dout); end
      vectors++; if (tx_line !== 1'b1)   begin miscompares++; $display("FAIL rst_tx: got %b want 1", tx_line); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
      vectors++; if (rx_ovf !== 1'b0)    begin miscompares++; $display("FAIL rst_rx_ovf: got %b want 0", rx_ovf); end
      vectors++; if (u_wa !== 1'b1)      begin miscompares++; $display("FAIL rst_u_wa: got %b want 1", u_wa); end
      vectors++; if (u_ra !== 1'b0)      begin miscompares++; $display("FAIL rst_u_ra: got %b want 0", u_ra); end
      rst = 1'b0;
      @(negedge clk);
      $display("reset done");
   endtask

   task automatic test_single_tx;
      bit ok;
      logic [9:0] f, want;
      want = frame_of(8'hA5);
      write_byte(8'hA5, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL tx1_ack: got %b want 1", ok); end
      @(negedge clk);
      vectors++; if (u_wack !== 1'b0)  begin miscompares++; $display("FAIL tx1_ack_pulse: got %b want 0", u_wack); end
      vectors++; if (tx_line !== 1'b1) begin miscompares++; $display("FAIL tx1_lat1: got %b want 1", tx_line); end
      @(negedge clk);
      vectors++; if (tx_line !== 1'b0) begin miscompares++; $display("FAIL tx1_lat2: got %b want 0", tx_line); end
      sample_frame(f);
      vectors++; if (f !== want) begin miscompares++; $display("FAIL tx1_frame: got %b want %b", f, want); end
      $display("tx frame 0x%02h bits %b", 8'hA5, f);
   endtask

   task automatic test_loopback;
      bit ok;
      logic [7:0] tv [3];
      logic [7:0] d, want;
      bit got;
      tv = '{8'hC0, 8'h01, 8'h7F};
      want = 8'h00;
      loopback = 1'b1;
      for (int i = 0; i < 3; i++) begin
         write_byte(tv[i], ok);
         vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL lb_write%0d: got %b want 1", i, ok); end
         exp_q.push_back(tv[i]);
      end
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (u_ra === 1'b1) got = 1'b1;
      end
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL lb_u_ra: got %b want 1", got); end
      for (int i = 0; i < 3; i++) begin
         read_byte(d, ok);
         want = exp_q.pop_front();
         vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL lb_rack%0d: got %b want 1", i, ok); end
         vectors++; if (d !== want)  begin miscompares++; $display("FAIL lb_data%0d: got %h want %h", i, d, want); end
      end
      @(negedge clk);
      vectors++; if (u_dout !== want) begin miscompares++; $display("FAIL lb_hold: got %h want %h", u_dout, want); end
      vectors++; if (u_rack !== 1'b0) begin miscompares++; $display("FAIL lb_rack_pulse: got %b want 0", u_rack); end
      loopback = 1'b0;
   endtask

   task automatic test_back_to_back;
      bit ok, got;
      int acks, fall_cyc, ack_cyc;
      // A frame of 0xFF keeps Tx busy and high after its start bit.
      write_byte(8'hFF, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL bp_prime: got %b want 1", ok); end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (tx_line === 1'b0) got = 1'b1;
      end
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL bp_start: got %b want 1", got); end
      u_din = 8'h11;
      u_we  = 1'b1;
      acks  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_wack === 1'b1) begin
            acks++;
            u_din = u_din + 8'd1;
         end
      end
      vectors++; if (acks != 4)     begin miscompares++; $display("FAIL bp_acks: got %0d want 4", acks); end
      vectors++; if (u_wa !== 1'b0) begin miscompares++; $display("FAIL bp_u_wa: got %b want 0", u_wa); end
      // The pop is visible as the start bit one cycle later; the ack lands then too.
      fall_cyc = -1;
      ack_cyc  = -1;
      for (int i = 0; i < 150 && (fall_cyc < 0 || ack_cyc < 0); i++) begin
         @(negedge clk);
         if (fall_cyc < 0 && tx_line === 1'b0) fall_cyc = cyc;
         if (ack_cyc < 0 && u_wack === 1'b1) begin
            ack_cyc = cyc;
            u_we = 1'b0;
         end
      end
      u_we = 1'b0;
      vectors++; if (fall_cyc < 0 || ack_cyc < 0) begin miscompares++; $display("FAIL bp_ack5_seen: got fall=%0d ack=%0d want both", fall_cyc, ack_cyc); end
      vectors++; if (ack_cyc != fall_cyc) begin miscompares++; $display("FAIL bp_ack5_time: got cycle %0d want %0d", ack_cyc, fall_cyc); end
      $display("backpressure acks=%0d ack5 cycle %0d", acks, ack_cyc);
   endtask

   task automatic test_rx_overflow;
      bit ok;
      int ovf_base;
      logic [7:0] tv [5];
      logic [7:0] d, want;
      tv = '{8'h3A, 8'hC5, 8'h0F, 8'hF0, 8'h99};
      ovf_base = ovf_cnt;
      for (int i = 0; i < 5; i++) begin
         send_rx(tv[i], 1'b1);
         if (i < 4) exp_q.push_back(tv[i]);
      end
      repeat (4) @(negedge clk);
      vectors++; if (ovf_cnt - ovf_base != 1) begin miscompares++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - ovf_base); end
      vectors++; if (u_ra !== 1'b1) begin miscompares++; $display("FAIL ovf_u_ra: got %b want 1", u_ra); end
      for (int i = 0; i < 4; i++) begin
         read_byte(d, ok);
         want = exp_q.pop_front();
         vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ovf_rack%0d: got %b want 1", i, ok); end
         vectors++; if (d !== want)  begin miscompares++; $display("FAIL ovf_data%0d: got %h want %h", i, d, want); end
      end
      @(negedge clk);
      vectors++; if (u_ra !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got %b want 0", u_ra); end
   endtask

   task automatic test_rx_errors;
      int fb, ob;
      fb = ferr_cnt;
      ob = ovf_cnt;
      send_rx(8'h3C, 1'b0);
      repeat (4) @(negedge clk);
      vectors++; if (ferr_cnt - fb != 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt - fb); end
      vectors++; if (u_ra !== 1'b0) begin miscompares++; $display("FAIL ferr_u_ra: got %b want 0", u_ra); end
      rx_drive = 1'b0;
      repeat (3) @(negedge clk);
      rx_drive = 1'b1;
      repeat (100) @(negedge clk);
      $display("rx glitch 3 cycles");
      vectors++; if (ferr_cnt - fb != 1) begin miscompares++; $display("FAIL glitch_ferr: got %0d want 1", ferr_cnt - fb); end
      vectors++; if (ovf_cnt - ob != 0)  begin miscompares++; $display("FAIL glitch_ovf: got %0d want 0", ovf_cnt - ob); end
      vectors++; if (u_ra !== 1'b0) begin miscompares++; $display("FAIL glitch_u_ra: got %b want 0", u_ra); end
   endtask

   task automatic test_reset_mid_frame;
      bit ok, got;
      int quiet;
      logic [9:0] f, want;
      quiet = 0;
      for (int i = 0; i < 1500 && quiet < 90; i++) begin
         @(negedge clk);
         quiet = (tx_line === 1'b1) ? quiet + 1 : 0;
      end
      vectors++; if (quiet < 90) begin miscompares++; $display("FAIL rm_tx_drain: got %0d idle cycles want 90", quiet); end
      send_rx(8'h12, 1'b1);
      send_rx(8'h34, 1'b1);
      vectors++; if (u_ra !== 1'b1) begin miscompares++; $display("FAIL rm_pre_u_ra: got %b want 1", u_ra); end
      write_byte(8'h00, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rm_write: got %b want 1", ok); end
      repeat (22) @(negedge clk);
      vectors++; if (tx_line !== 1'b0) begin miscompares++; $display("FAIL rm_midframe: got %b want 0", tx_line); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("reset asserted mid-frame");
      vectors++; if (tx_line !== 1'b1) begin miscompares++; $display("FAIL rm_tx: got %b want 1", tx_line); end
      vectors++; if (u_ra !== 1'b0)    begin miscompares++; $display("FAIL rm_u_ra: got %b want 0", u_ra); end
      vectors++; if (u_wa !== 1'b1)    begin miscompares++; $display("FAIL rm_u_wa: got %b want 1", u_wa); end
      vectors++; if (u_dout !== 8'h00) begin miscompares++; $display("FAIL rm_u_dout: got %h want 00", u_dout); end
      want = frame_of(8'h55);
      write_byte(8'h55, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rm_write55: got %b want 1", ok); end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (tx_line === 1'b0) got = 1'b1;
      end
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rm_start: got %b want 1", got); end
      sample_frame(f);
      vectors++; if (f !== want) begin miscompares++; $display("FAIL rm_frame: got %b want %b", f, want); end
      $display("tx frame 0x%02h bits %b", 8'h55, f);
   endtask

   initial begin
      rst      = 1'b1;
      u_we     = 1'b0;
      u_re     = 1'b0;
      u_din    = 8'h00;
      rx_drive = 1'b1;
      loopback = 1'b0;
      test_reset();
      test_single_tx();
      test_loopback();
      test_back_to_back();
      test_rx_overflow();
      test_rx_errors();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
